// File: rtl/shift_add_mult4b.sv
// Sequential 4x4 unsigned shift-and-add multiplier: IDLE -> 4x CALC -> DONE.
// Optional early completion once the remaining multiplier bits are zero: `define EARLY_DONE_EN.

module fullAdder4b (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
endmodule

module shift_add_mult4b (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] product
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t     state, state_nxt;
  logic [3:0] mcand, mplier, hi, lo;
  logic [2:0] cnt;
  logic [3:0] add_sum, hsum;
  logic       add_cout, carry;
  logic [3:0] hi_nxt, lo_nxt, mplier_nxt;
  logic       last_iter;
  logic [7:0] result;

  fullAdder4b u_add (
    .a    (hi),
    .b    (mcand),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // One iteration: conditional add, then shift {carry,hi,lo} and the multiplier right.
  always_comb begin
    carry      = mplier[0] ? add_cout : 1'b0;
    hsum       = mplier[0] ? add_sum  : hi;
    hi_nxt     = {carry, hsum[3:1]};
    lo_nxt     = {hsum[0], lo[3:1]};
    mplier_nxt = {1'b0, mplier[3:1]};
`ifdef EARLY_DONE_EN
    // Low bits of lo not yet overwritten by shifted-in product bits are dropped by this shift.
    last_iter  = (cnt == 3'd3) || (mplier_nxt == 4'd0);
    result     = {hi_nxt, lo_nxt} >> (3'd3 - cnt);
`else
    last_iter  = (cnt == 3'd3);
    result     = {hi_nxt, lo_nxt};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CALC);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= 4'd0;
      mplier  <= 4'd0;
      hi      <= 4'd0;
      lo      <= 4'd0;
      cnt     <= 3'd0;
      product <= 8'h00;
    end else if (state == IDLE && start) begin
      mcand  <= a;
      mplier <= b;
      hi     <= 4'd0;
      cnt    <= 3'd0;
    end else if (state == CALC) begin
      hi     <= hi_nxt;
      lo     <= lo_nxt;
      mplier <= mplier_nxt;
      cnt    <= cnt + 3'd1;
      if (last_iter) product <= result;
    end
  end

endmodule
